// File: rtl/signal_phase_controller.sv
// Traffic-light phase sequencer: ALLRED/GREEN/YELLOW/PED/NIGHT/EMERG with min/max green and clearances.
// Outputs decode registered state only (one-cycle response to inputs); no backpressure, requests are sampled every cycle.
module signal_phase_controller #(
    parameter int GREEN_MIN   = 8,
    parameter int GREEN_MAX   = 30,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int PED_TIME    = 10,
    parameter int FLASH_HALF  = 4,
    parameter int CNT_W       = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir_req,
    input  logic       ped_req,
    input  logic [3:0] emerg_req,
    input  logic       night_mode,
    output logic [7:0] lane_green,
    output logic [3:0] yellow,
    output logic       ped_walk,
    output logic [1:0] cur_dir,
    output logic [2:0] state,
    output logic       phase_done
);

    localparam logic [2:0] S_ALLRED = 3'd0;
    localparam logic [2:0] S_GREEN  = 3'd1;
    localparam logic [2:0] S_YELLOW = 3'd2;
    localparam logic [2:0] S_PED    = 3'd3;
    localparam logic [2:0] S_NIGHT  = 3'd4;
    localparam logic [2:0] S_EMERG  = 3'd5;

    localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] T_PED  = CNT_W'(PED_TIME - 1);
    localparam logic [CNT_W-1:0] T_FH   = CNT_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0] timer;
    logic             ped_lat;
    logic             flash;
    logic [2:0]       state_nx;
    logic [1:0]       dir_nx;

    // Lowest set bit wins, so North has the highest priority.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_nx = state;
        dir_nx   = cur_dir;
        case (state)
            S_ALLRED: begin
                if (timer >= T_AR) begin
                    if (|emerg_req) begin
                        state_nx = S_EMERG;
                        dir_nx   = enc4(emerg_req);
                    end else if (ped_lat) begin
                        state_nx = S_PED;
                    end else if (night_mode) begin
                        state_nx = S_NIGHT;
                    end else if (|dir_req) begin
                        state_nx = S_GREEN;
                        dir_nx   = enc4(dir_req);
                    end
                end
            end
            S_GREEN: begin
                if (|emerg_req) begin
                    state_nx = (enc4(emerg_req) == cur_dir) ? S_EMERG : S_YELLOW;
                end else if (timer >= T_GMAX) begin
                    state_nx = S_YELLOW;
                end else if (timer >= T_GMIN &&
                             (((|dir_req) && enc4(dir_req) != cur_dir) || ped_lat || night_mode)) begin
                    state_nx = S_YELLOW;
                end
            end
            S_YELLOW: if (timer == T_YEL) state_nx = S_ALLRED;
            S_PED:    if (timer == T_PED) state_nx = S_ALLRED;
            S_NIGHT:  if (!night_mode || ped_lat || (|emerg_req)) state_nx = S_ALLRED;
            S_EMERG:  if (!emerg_req[cur_dir]) state_nx = S_YELLOW;
            default:  state_nx = S_ALLRED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ALLRED;
            timer      <= '0;
            cur_dir    <= 2'd0;
            ped_lat    <= 1'b0;
            flash      <= 1'b0;
            phase_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cur_dir    <= dir_nx;
            phase_done <= (state == S_GREEN || state == S_EMERG) && state_nx == S_YELLOW;

            // In NIGHT the timer doubles as the flash half-period counter.
            if (state_nx != state)
                timer <= '0;
            else if (state == S_NIGHT && timer == T_FH)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + 1'b1;

            if (state_nx == S_PED && state != S_PED)
                ped_lat <= 1'b0;
            else if (ped_req)
                ped_lat <= 1'b1;

            if (state_nx == S_NIGHT && state != S_NIGHT)
                flash <= 1'b0;
            else if (state == S_NIGHT && timer == T_FH)
                flash <= ~flash;
        end
    end

    always_comb begin
        lane_green = '0;
        yellow     = '0;
        ped_walk   = 1'b0;
        case (state)
            S_GREEN, S_EMERG: lane_green = 8'b11 << {cur_dir, 1'b0};
            S_YELLOW:         yellow     = 4'b1 << cur_dir;
            S_PED:            ped_walk   = 1'b1;
            S_NIGHT:          yellow     = {4{flash}};
            default:          ;
        endcase
    end

endmodule

// File: tb/tb_signal_phase_controller.sv
// Bench for signal_phase_controller: directed scenarios plus random traffic against a phase-level reference model.
module tb_signal_phase_controller;

    localparam int GREEN_MIN   = 8;
    localparam int GREEN_MAX   = 30;
    localparam int YELLOW_TIME = 3;
    localparam int ALLRED_TIME = 2;
    localparam int PED_TIME    = 10;
    localparam int FLASH_HALF  = 4;

    localparam int P_ALLRED = 0, P_GREEN = 1, P_YELLOW = 2, P_PED = 3, P_NIGHT = 4, P_EMERG = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dir_req;
    logic       ped_req;
    logic [3:0] emerg_req;
    logic       night_mode;
    logic [7:0] lane_green;
    logic [3:0] yellow;
    logic       ped_walk;
    logic [1:0] cur_dir;
    logic [2:0] state;
    logic       phase_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: current phase, cycles spent in it, served direction, pending walk.
    int m_ph, m_e, m_dir;
    bit m_ped, m_done;

    signal_phase_controller #(
        .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_TIME(YELLOW_TIME),
        .ALLRED_TIME(ALLRED_TIME), .PED_TIME(PED_TIME), .FLASH_HALF(FLASH_HALF), .CNT_W(6)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir_req(dir_req), .ped_req(ped_req),
        .emerg_req(emerg_req), .night_mode(night_mode), .lane_green(lane_green),
        .yellow(yellow), .ped_walk(ped_walk), .cur_dir(cur_dir), .state(state),
        .phase_done(phase_done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lowbit(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_ph = P_ALLRED; m_e = 0; m_dir = 0; m_ped = 0; m_done = 0;
    endtask

    task automatic model_step();
        int nph, ndir;
        nph = m_ph; ndir = m_dir;
        case (m_ph)
            P_ALLRED: if (m_e >= ALLRED_TIME - 1) begin
                if (emerg_req != 0) begin nph = P_EMERG; ndir = lowbit(emerg_req); end
                else if (m_ped) nph = P_PED;
                else if (night_mode) nph = P_NIGHT;
                else if (dir_req != 0) begin nph = P_GREEN; ndir = lowbit(dir_req); end
            end
            P_GREEN: begin
                if (emerg_req != 0) nph = (lowbit(emerg_req) == m_dir) ? P_EMERG : P_YELLOW;
                else if (m_e + 1 >= GREEN_MAX) nph = P_YELLOW;
                else if (m_e + 1 >= GREEN_MIN &&
                         ((dir_req != 0 && lowbit(dir_req) != m_dir) || m_ped || night_mode))
                    nph = P_YELLOW;
            end
            P_YELLOW: if (m_e + 1 == YELLOW_TIME) nph = P_ALLRED;
            P_PED:    if (m_e + 1 == PED_TIME) nph = P_ALLRED;
            P_NIGHT:  if (!night_mode || m_ped || emerg_req != 0) nph = P_ALLRED;
            P_EMERG:  if (!emerg_req[m_dir]) nph = P_YELLOW;
            default:  nph = P_ALLRED;
        endcase
        m_done = (m_ph == P_GREEN || m_ph == P_EMERG) && nph == P_YELLOW;
        m_ped  = (nph == P_PED && m_ph != P_PED) ? 1'b0 : (m_ped | ped_req);
        m_e    = (nph == m_ph) ? m_e + 1 : 0;
        m_ph   = nph;
        m_dir  = ndir;
    endtask

    task automatic compare_all();
        logic [7:0] eg;
        logic [3:0] ey;
        eg = '0; ey = '0;
        if (m_ph == P_GREEN || m_ph == P_EMERG) eg = 8'b11 << (2 * m_dir);
        if (m_ph == P_YELLOW) ey = 4'b1 << m_dir;
        if (m_ph == P_NIGHT && ((m_e / FLASH_HALF) % 2) == 1) ey = 4'b1111;
        check_val("state", 32'(state), 32'(m_ph));
        check_val("lane_green", 32'(lane_green), 32'(eg));
        check_val("yellow", 32'(yellow), 32'(ey));
        check_val("ped_walk", 32'(ped_walk), 32'(m_ph == P_PED));
        check_val("cur_dir", 32'(cur_dir), 32'(m_dir));
        check_val("phase_done", 32'(phase_done), 32'(m_done));
    endtask

    // One clock: check outputs on the falling edge, then drive the next inputs.
    task automatic step(input logic [3:0] d, input logic p, input logic [3:0] e, input logic n);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        dir_req = d; ped_req = p; emerg_req = e; night_mode = n;
        model_step();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_lights", 32'({lane_green, yellow, ped_walk}), 32'd0);
        check_val("rst_state", 32'({state, cur_dir, phase_done}), 32'd0);
        model_reset();
    endtask

    logic [3:0] r_dir, r_emerg;
    logic       r_night, r_ped;
    int         g_cnt, d_cnt;

    initial begin
        rst_n = 1'b0; dir_req = '0; ped_req = 0; emerg_req = '0; night_mode = 0;
        model_reset();

        // Release with East demand: two ALLRED cycles, then East green.
        for (int k = 1; k <= 3; k++) step(4'b0010, 0, 4'b0, 0);
        check_val("first_green", 32'(lane_green), 32'h0C);
        check_val("first_dir", 32'(cur_dir), 32'd1);
        // Demand moves to North: green holds to minimum, then clearance.
        for (int k = 0; k < 20; k++) step(4'b0001, 0, 4'b0, 0);

        // Max green with constant same-direction demand.
        do_reset();
        g_cnt = 0; d_cnt = 0;
        for (int k = 1; k <= 36; k++) begin
            step(4'b0010, 0, 4'b0, 0);
            if (state == 3'd1) g_cnt++;
            if (phase_done) d_cnt++;
        end
        check_val("max_green_len", 32'(g_cnt), 32'd30);
        check_val("max_green_done", 32'(d_cnt), 32'd1);

        // Emergency to South preempts North green.
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0001, 0, 4'b0, 0);
        for (int k = 0; k < 15; k++) step(4'b0001, 0, 4'b0100, 0);
        for (int k = 0; k < 8; k++) step(4'b0001, 0, 4'b0, 0);

        // Pedestrian pulse during green, second pulse during walk.
        do_reset();
        for (int k = 1; k <= 45; k++) step(4'b0001, (k == 4 || k == 20), 4'b0, 0);

        // Night flashing, then async reset in the middle of it.
        do_reset();
        for (int k = 0; k < 20; k++) step(4'b0001, 0, 4'b0, 1);
        do_reset();
        step(4'b0001, 0, 4'b0, 0);

        // Random traffic with slowly changing demand regimes.
        r_dir = 4'b0001; r_emerg = '0; r_night = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(19) == 0)
                r_dir = ($urandom_range(1) == 0) ? (4'b1 << $urandom_range(3)) : 4'($urandom);
            if ($urandom_range(79) == 0)
                r_emerg = (r_emerg == 0) ? 4'($urandom) : 4'b0;
            if ($urandom_range(149) == 0) r_night = ~r_night;
            r_ped = ($urandom_range(39) == 0);
            step(r_dir, r_ped, r_emerg, r_night);
            if ($urandom_range(999) == 0) do_reset();
        end
        step(4'b0, 0, 4'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
